alu_mdu: RTL and testbench

Parametrised successor to the core execute-stage ALU. Adds a valid/ready handshake, a registered result and multi-cycle multiply/divide/remainder (RV32M semantics), so the EX stage can stall on long operations. It sits in EX between the ID/EX operand muxes and the EX/MEM register. PC-to-reg and CSR pass-through stay in the EX result mux outside this block.

---
 rtl/alu_mdu_pkg.sv | 35 +++
 rtl/mdu_divider.sv | 77 +++++++
 rtl/alu_mdu.sv | 236 +++++++++++++++++++++++
 tb/tb_alu_mdu.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mdu_pkg.sv
// Shared types and constants for the execute-stage ALU/MDU.
package alu_mdu_pkg;

   localparam int unsigned XLEN_DEF = 32;
   localparam int unsigned SHAMT_W  = $clog2(XLEN_DEF);

   typedef enum logic [4:0] {
      OP_ADD    = 5'd0,
      OP_SUB    = 5'd1,
      OP_AND    = 5'd2,
      OP_OR     = 5'd3,
      OP_XOR    = 5'd4,
      OP_SLT    = 5'd5,
      OP_SLTU   = 5'd6,
      OP_SLL    = 5'd7,
      OP_SRL    = 5'd8,
      OP_SRA    = 5'd9,
      OP_MUL    = 5'd10,
      OP_MULH   = 5'd11,
      OP_MULHSU = 5'd12,
      OP_MULHU  = 5'd13,
      OP_DIV    = 5'd14,
      OP_DIVU   = 5'd15,
      OP_REM    = 5'd16,
      OP_REMU   = 5'd17
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/mdu_divider.sv
// Iterative radix-2 restoring unsigned divider, one quotient bit per cycle.
// The first step is taken on the start edge, so done pulses XLEN edges
// after start with quotient/remainder already registered.
module mdu_divider #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder,
   output logic            done
);

   localparam int unsigned CNT_W = $clog2(XLEN) + 1;

   logic [XLEN-1:0]  rem_q, quo_q, dvsr_q;
   logic [XLEN-1:0]  rem_src, quo_src, dvsr_src;
   logic [XLEN-1:0]  rem_nx, quo_nx;
   logic [XLEN:0]    trial, diff;
   logic [CNT_W-1:0] cnt;
   logic             running;

   // One restoring step, fed from the ports on start and from the registers otherwise.
   always_comb begin
      rem_src  = start ? '0       : rem_q;
      quo_src  = start ? dividend : quo_q;
      dvsr_src = start ? divisor  : dvsr_q;
      trial    = {rem_src, quo_src[XLEN-1]};
      diff     = trial - {1'b0, dvsr_src};
      if (diff[XLEN]) begin
         rem_nx = trial[XLEN-1:0];
         quo_nx = {quo_src[XLEN-2:0], 1'b0};
      end else begin
         rem_nx = diff[XLEN-1:0];
         quo_nx = {quo_src[XLEN-2:0], 1'b1};
      end
   end

   // Iteration registers and step counter; abort drops the division silently.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q   <= '0;
         quo_q   <= '0;
         dvsr_q  <= '0;
         cnt     <= '0;
         running <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            running <= 1'b0;
         end else if (start) begin
            rem_q   <= rem_nx;
            quo_q   <= quo_nx;
            dvsr_q  <= divisor;
            cnt     <= CNT_W'(XLEN - 1);
            running <= 1'b1;
         end else if (running) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt   <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               running <= 1'b0;
               done    <= 1'b1;
            end
         end
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with multi-cycle RV32M multiply/divide and valid/ready
// handshakes on both sides. Define FAST_MUL_EN to replace the iterative
// multiplier with a single-cycle combinational product.
module alu_mdu
   import alu_mdu_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       op,
   input  logic [XLEN-1:0]  src1,
   input  logic [XLEN-1:0]  src2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  result,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   // Package constant covers the default width; other widths derive their own.
   localparam int unsigned SH_W    = (XLEN == XLEN_DEF) ? SHAMT_W : $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};

   state_e            state, state_d;
   logic              out_valid_d, busy_d;
   logic [XLEN-1:0]   result_d;
   logic [TAG_W-1:0]  out_tag_d;

   logic              accept, out_hs;
   logic              is_mul, is_div, a_signed, b_signed, sel_hi_op;
   logic              div_zero, div_ovf, div_special;
   logic              go_mul, go_div, single;
   logic              s1_neg, s2_neg;
   logic [XLEN-1:0]   mag1, mag2;
   logic [SH_W-1:0]   shamt;
   logic [XLEN-1:0]   quick_res;

   logic              neg_q, neg_r, sel_hi;
   logic [XLEN-1:0]   div_q, div_r, div_res;
   logic              div_done;
   logic              mul_last;
   logic [XLEN-1:0]   mul_res;

   assign out_hs   = out_valid && out_ready;
   assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush;
   assign accept   = in_valid && in_ready;
   assign shamt    = src2[SH_W-1:0];

   // Op decode, operand signs/magnitudes and divide corner cases.
   always_comb begin
      is_mul    = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
      is_div    = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
      a_signed  = op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
      b_signed  = op inside {OP_MULH, OP_DIV, OP_REM};
      sel_hi_op = op inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};
      s1_neg    = a_signed && src1[XLEN-1];
      s2_neg    = b_signed && src2[XLEN-1];
      mag1      = s1_neg ? -src1 : src1;
      mag2      = s2_neg ? -src2 : src2;
      div_zero  = (src2 == '0);
      div_ovf   = (op inside {OP_DIV, OP_REM}) && (src1 == MIN_VAL) && (src2 == ONES);
      div_special = div_zero || div_ovf;
   end

`ifdef FAST_MUL_EN
   logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;

   // Sign-extended operands give the exact low 2*XLEN product bits for every MUL* variant.
   assign fast_a    = {{XLEN{s1_neg}}, src1};
   assign fast_b    = {{XLEN{s2_neg}}, src2};
   assign fast_prod = fast_a * fast_b;
   assign go_mul    = 1'b0;
   assign mul_last  = 1'b0;
   assign mul_res   = '0;
`else
   localparam int unsigned CNT_W = SH_W + 1;

   logic [XLEN-1:0]   p_hi, p_lo, mcand;
   logic [CNT_W-1:0]  mul_cnt;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] p_next, p_signed;

   assign go_mul   = accept && is_mul;
   assign mul_last = (state == MUL) && (mul_cnt == CNT_W'(1));

   // Shift-add step on magnitudes; the last step feeds the sign fix-up directly.
   always_comb begin
      mul_sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : '0);
      p_next   = {mul_sum, p_lo[XLEN-1:1]};
      p_signed = neg_q ? -p_next : p_next;
      mul_res  = sel_hi ? p_signed[2*XLEN-1:XLEN] : p_signed[XLEN-1:0];
   end

   // Iterative multiplier registers: product halves, multiplicand, step count.
   always_ff @(posedge clk) begin
      if (rst) begin
         p_hi    <= '0;
         p_lo    <= '0;
         mcand   <= '0;
         mul_cnt <= '0;
      end else if (go_mul) begin
         p_hi    <= '0;
         p_lo    <= mag2;
         mcand   <= mag1;
         mul_cnt <= CNT_W'(XLEN);
      end else if (state == MUL) begin
         {p_hi, p_lo} <= p_next;
         mul_cnt      <= mul_cnt - CNT_W'(1);
      end
   end
`endif

   assign go_div = accept && is_div && !div_special;
   assign single = accept && !go_div && !go_mul;

   // Single-cycle results, including the divide corner cases.
   always_comb begin
      quick_res = '0;
      case (op)
         OP_ADD:  quick_res = src1 + src2;
         OP_SUB:  quick_res = src1 - src2;
         OP_AND:  quick_res = src1 & src2;
         OP_OR:   quick_res = src1 | src2;
         OP_XOR:  quick_res = src1 ^ src2;
         OP_SLT:  quick_res = XLEN'($signed(src1) < $signed(src2));
         OP_SLTU: quick_res = XLEN'(src1 < src2);
         OP_SLL:  quick_res = src1 << shamt;
         OP_SRL:  quick_res = src1 >> shamt;
         OP_SRA:  quick_res = XLEN'($signed(src1) >>> shamt);
`ifdef FAST_MUL_EN
         OP_MUL:    quick_res = fast_prod[XLEN-1:0];
         OP_MULH,
         OP_MULHSU,
         OP_MULHU:  quick_res = fast_prod[2*XLEN-1:XLEN];
`endif
         OP_DIV,
         OP_DIVU: quick_res = div_zero ? ONES : MIN_VAL;
         OP_REM,
         OP_REMU: quick_res = div_zero ? src1 : '0;
         default: quick_res = '0;
      endcase
   end

   mdu_divider #(.XLEN(XLEN)) u_divider (
      .clk       (clk),
      .rst       (rst),
      .start     (go_div),
      .abort     (flush),
      .dividend  (mag1),
      .divisor   (mag2),
      .quotient  (div_q),
      .remainder (div_r),
      .done      (div_done)
   );

   // Quotient takes the xor of operand signs, remainder the dividend sign.
   always_comb begin
      if (sel_hi) div_res = neg_r ? -div_r : div_r;
      else        div_res = neg_q ? -div_q : div_q;
   end

   // Sign and half-select flags captured with each accepted op.
   always_ff @(posedge clk) begin
      if (rst) begin
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         sel_hi <= 1'b0;
      end else if (accept) begin
         neg_q  <= s1_neg ^ s2_neg;
         neg_r  <= s1_neg;
         sel_hi <= sel_hi_op;
      end
   end

   // Next state and next registered outputs; flush overrides everything.
   always_comb begin
      state_d     = state;
      out_valid_d = out_valid;
      result_d    = result;
      out_tag_d   = out_tag;
      case (state)
         IDLE: begin
            if (go_mul)      state_d = MUL;
            else if (go_div) state_d = DIV;
         end
         MUL:     if (mul_last) state_d = DONE;
         DIV:     if (div_done) state_d = DONE;
         DONE:    if (out_hs)   state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (out_hs) out_valid_d = 1'b0;
      if (accept) out_tag_d = in_tag;
      if (single) begin
         out_valid_d = 1'b1;
         result_d    = quick_res;
      end
      if (mul_last) begin
         out_valid_d = 1'b1;
         result_d    = mul_res;
      end
      if ((state == DIV) && div_done) begin
         out_valid_d = 1'b1;
         result_d    = div_res;
      end
      if (flush) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
      end
      busy_d = (state_d == MUL) || (state_d == DIV);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         out_tag   <= '0;
         busy      <= 1'b0;
      end else begin
         state     <= state_d;
         out_valid <= out_valid_d;
         result    <= result_d;
         out_tag   <= out_tag_d;
         busy      <= busy_d;
      end
   end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed table, handshake/flush/reset
// sequences and random ops against an arithmetic reference model.
module tb_alu_mdu;

   localparam logic [31:0] MINV = 32'h8000_0000;
   localparam logic [31:0] ONES = 32'hFFFF_FFFF;
`ifdef FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
   logic [4:0]  op, in_tag, out_tag;
   logic [31:0] src1, src2, result;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   alu_mdu #(.XLEN(32), .TAG_W(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .src1      (src1),
      .src2      (src2),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .out_tag   (out_tag),
      .busy      (busy)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference results straight from the RV32M definitions using 64-bit arithmetic.
   function automatic logic [31:0] ref_res(input logic [4:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      p  = 64'd0;
      case (o)
         5'd0:  return a + b;
         5'd1:  return a - b;
         5'd2:  return a & b;
         5'd3:  return a | b;
         5'd4:  return a ^ b;
         5'd5:  return (sa < sb) ? 32'd1 : 32'd0;
         5'd6:  return (ua < ub) ? 32'd1 : 32'd0;
         5'd7:  return a << b[4:0];
         5'd8:  return a >> b[4:0];
         5'd9:  return 32'(sa >>> b[4:0]);
         5'd10: begin p = 64'(sa * sb); return p[31:0];  end
         5'd11: begin p = 64'(sa * sb); return p[63:32]; end
         5'd12: begin p = 64'(sa * ub); return p[63:32]; end
         5'd13: begin p = 64'(ua * ub); return p[63:32]; end
         5'd14: begin
            if (b == 32'd0) return ONES;
            if (a == MINV && b == ONES) return MINV;
            return 32'(sa / sb);
         end
         5'd15: begin
            if (b == 32'd0) return ONES;
            return 32'(ua / ub);
         end
         5'd16: begin
            if (b == 32'd0) return a;
            if (a == MINV && b == ONES) return 32'd0;
            return 32'(sa % sb);
         end
         5'd17: begin
            if (b == 32'd0) return a;
            return 32'(ua % ub);
         end
         default: return 32'd0;
      endcase
   endfunction

   // Expected latency from the op class and the divide corner cases.
   function automatic int ref_lat(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
      if (o >= 5'd10 && o <= 5'd13) return MUL_LAT;
      if (o >= 5'd14 && o <= 5'd17) begin
         if (b == 32'd0) return 1;
         if ((o == 5'd14 || o == 5'd16) && a == MINV && b == ONES) return 1;
         return 33;
      end
      return 1;
   endfunction

   task automatic wait_ready();
      int cyc;
      cyc = 0;
      while (!in_ready && cyc < 100) begin
         tick();
         cyc++;
      end
      if (!in_ready) check("in_ready wait", 64'(in_ready), 64'd1);
   endtask

   // Issue one op, wait for its result and check value, tag, latency and busy time.
   task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tg, input logic [31:0] exp_r, input int lat);
      int cyc, bcnt;
      wait_ready();
      op = o; src1 = a; src2 = b; in_tag = tg; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      cyc  = 1;
      bcnt = 0;
      while (cyc < 200) begin
         if (busy) bcnt++;
         if (out_valid) break;
         tick();
         cyc++;
      end
      check($sformatf("op%0d out_valid", o), 64'(out_valid), 64'd1);
      check($sformatf("op%0d result a=%h b=%h", o, a, b), 64'(result), 64'(exp_r));
      check($sformatf("op%0d out_tag", o), 64'(out_tag), 64'(tg));
      check($sformatf("op%0d latency", o), 64'(cyc), 64'(lat));
      check($sformatf("op%0d busy cycles", o), 64'(bcnt), 64'((lat == 33) ? 32 : 0));
   endtask

   task automatic add(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] e, input int lat);
      vec_t v;
      v.op = o; v.a = a; v.b = b; v.exp = e; v.lat = lat;
      tbl.push_back(v);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt;
      logic [4:0]  ro;
      logic [31:0] ra, rb;

      add(5'd0,  32'h7FFF_FFFF, 32'd1,        32'h8000_0000, 1);
      add(5'd1,  32'd0,         32'd1,        ONES,          1);
      add(5'd5,  ONES,          32'd1,        32'd1,         1);
      add(5'd6,  ONES,          32'd1,        32'd0,         1);
      add(5'd7,  32'd1,         32'h21,       32'd2,         1);
      add(5'd8,  MINV,          32'd31,       32'd1,         1);
      add(5'd10, ONES,          ONES,         32'd1,         MUL_LAT);
      add(5'd11, ONES,          ONES,         32'd0,         MUL_LAT);
      add(5'd13, ONES,          ONES,         32'hFFFF_FFFE, MUL_LAT);
      add(5'd12, ONES,          ONES,         ONES,          MUL_LAT);
      add(5'd14, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
      add(5'd16, 32'hFFFF_FFF9, 32'd2,        ONES,          33);
      add(5'd15, 32'd5,         32'd0,        ONES,          1);
      add(5'd16, 32'd5,         32'd0,        32'd5,         1);
      add(5'd14, MINV,          ONES,         MINV,          1);
      add(5'd16, MINV,          ONES,         32'd0,         1);
      add(5'd17, 32'd100,       32'd7,        32'd2,         33);
      add(5'd15, ONES,          32'd1,        ONES,          33);
      add(5'd20, 32'd5,         32'd6,        32'd0,         1);

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op = 5'd0; src1 = 32'd0; src2 = 32'd0; in_tag = 5'd0;
      repeat (2) tick();
      rst = 1'b0;
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset result",    64'(result),    64'd0);
      check("reset out_tag",   64'(out_tag),   64'd0);
      check("reset busy",      64'(busy),      64'd0);
      check("reset in_ready",  64'(in_ready),  64'd1);

      foreach (tbl[i])
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, 5'(i), tbl[i].exp, tbl[i].lat);

      // ADD then SRA back-to-back with results on consecutive cycles.
      wait_ready();
      op = 5'd0; src1 = 32'h7FFF_FFFF; src2 = 32'd1; in_tag = 5'd3; in_valid = 1'b1;
      tick();
      check("b2b first valid", 64'(out_valid), 64'd1);
      check("b2b first result", 64'(result), 64'h8000_0000);
      check("b2b first tag", 64'(out_tag), 64'd3);
      check("b2b in_ready", 64'(in_ready), 64'd1);
      op = 5'd9; src1 = 32'h8000_0000; src2 = 32'd4; in_tag = 5'd4;
      tick();
      in_valid = 1'b0;
      check("b2b second valid", 64'(out_valid), 64'd1);
      check("b2b second result", 64'(result), 64'hF800_0000);
      check("b2b second tag", 64'(out_tag), 64'd4);
      tick();
      check("b2b drained", 64'(out_valid), 64'd0);

      // Backpressure: result held, pending op refused until the handshake.
      wait_ready();
      out_ready = 1'b0;
      op = 5'd2; src1 = 32'hF0F0_1234; src2 = 32'hFF00_FF00; in_tag = 5'd9; in_valid = 1'b1;
      tick();
      op = 5'd0; src1 = 32'h10; src2 = 32'h20; in_tag = 5'd10;
      for (int k = 0; k < 5; k++) begin
         check("stall out_valid", 64'(out_valid), 64'd1);
         check("stall result", 64'(result), 64'hF000_1200);
         check("stall out_tag", 64'(out_tag), 64'd9);
         check("stall in_ready", 64'(in_ready), 64'd0);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("release in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      check("release result", 64'(result), 64'h30);
      check("release out_tag", 64'(out_tag), 64'd10);
      tick();
      check("release drained", 64'(out_valid), 64'd0);

      // Flush in the middle of a divide.
      wait_ready();
      op = 5'd14; src1 = 32'd1000; src2 = 32'd3; in_tag = 5'd11; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (9) tick();
      check("flush pre busy", 64'(busy), 64'd1);
      flush = 1'b1;
      op = 5'd0; src1 = 32'd1; src2 = 32'd1; in_tag = 5'd12; in_valid = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("flush busy", 64'(busy), 64'd0);
      check("flush out_valid", 64'(out_valid), 64'd0);
      cnt = 0;
      repeat (40) begin
         if (out_valid) cnt++;
         tick();
      end
      check("flush no result", 64'(cnt), 64'd0);
      run_op(5'd0, 32'd2, 32'd3, 5'd13, 32'd5, 1);

      // Reset in the middle of a divide.
      wait_ready();
      op = 5'd15; src1 = 32'd999; src2 = 32'd7; in_tag = 5'd14; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (9) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst out_valid", 64'(out_valid), 64'd0);
      check("rst result", 64'(result), 64'd0);
      check("rst out_tag", 64'(out_tag), 64'd0);
      check("rst busy", 64'(busy), 64'd0);
      check("rst in_ready", 64'(in_ready), 64'd1);
      run_op(5'd1, 32'd10, 32'd3, 5'd15, 32'd7, 1);

      // Random ops with a bias toward divide corner operands.
      for (int i = 0; i < 150; i++) begin
         ro = 5'($urandom_range(0, 31));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = MINV; rb = ONES; end
            2: rb = 32'($urandom_range(1, 9));
            3: ra = 32'($urandom_range(0, 99));
            default: ;
         endcase
         run_op(ro, ra, rb, 5'(i), ref_res(ro, ra, rb), ref_lat(ro, ra, rb));
      end

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
